ca_prng_engine: RTL and testbench
=================================

// Module: ca_prng_engine
// PURPOSE
//  Parametrised 1-D elementary cellular-automaton PRNG; successor to our fixed 64-bit Rule 90 generator.
//  Adds: any 8-bit Wolfram rule, periodic/null boundary, multi-step bursts, explicit command opcodes, valid/ready output.
//  Sits between the SPI command decoder (cmd_*) and the SPI response path (out_*).
// PARAMETERS
//  WIDTH          64   number of CA cells (>=3)
//  STEP_W         8    width of burst step count; max burst 2**STEP_W-1 steps
//  RULE_DEFAULT   90   Wolfram rule loaded at reset (0..255)
//  BOUND_DEFAULT  0    boundary at reset: 0 = periodic (wrap), 1 = null (edge neighbours read 0)
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      engine can accept a command
//  cmd_op     in   2      00 STEP, 01 LOAD_SEED, 10 SET_RULE, 11 reserved
//  cmd_data   in   WIDTH  STEP: [STEP_W-1:0]=n; LOAD_SEED: seed; SET_RULE: [7:0]=rule, [8]=boundary
//  out_valid  out  1      out_data holds a completed STEP result
//  out_ready  in   1      consumer takes out_data
//  out_data   out  WIDTH  CA state snapshot
//  busy       out  1      high in RUN or OUT
//  zero_state out  1      CA state is all-zero (combinational from state register)
//  cmd_err    out  1      one-cycle pulse on accepted reserved opcode
//  led_sig    out  1      toggles on every accepted command
// BEHAVIOUR
//  Reset (async, reset=0): state=0, rule=RULE_DEFAULT, bound=BOUND_DEFAULT, FSM=IDLE, out_valid=0,
//   out_data=0, cmd_err=0, led_sig=0, step counter=0; cmd_ready=0 while reset is low.
//  Cell update: cell i next = rule[{L,C,R}], L=q[i+1], C=q[i], R=q[i-1]; all cells update together.
//   Periodic: q[WIDTH]=q[0], q[-1]=q[WIDTH-1]. Null: both out-of-range neighbours are 0.
//  Accept = cmd_valid & cmd_ready at a rising edge; cmd_ready = (FSM==IDLE).
//  FSM states IDLE, RUN, OUT:
//   IDLE, accept LOAD_SEED -> state=cmd_data (zero seed allowed; zero_state then 1); stay IDLE.
//   IDLE, accept SET_RULE  -> rule/bound updated; state unchanged; stay IDLE.
//   IDLE, accept op 11     -> nothing else changes; cmd_err=1 for one cycle; stay IDLE.
//   IDLE, accept STEP n=0  -> out_data=state, out_valid=1 on the accept edge; go to OUT.
//   IDLE, accept STEP n>0  -> counter=n; go to RUN.
//   RUN: one CA step per clock, counter decrements. The edge applying step n also loads
//        out_data=new state, sets out_valid=1 and enters OUT. out_valid rises n edges after the accept edge.
//   OUT: out_valid and out_data held stable until out_valid&out_ready; on that edge out_valid=0 -> IDLE.
//  A command accepted in IDLE is always handled to completion before the next is accepted.
//  A new rule applies only to steps of later STEP commands.
//  led_sig toggles on every accept, all opcodes included.
//  All-zero state is a fixed point for rules with rule[0]=0; no auto-reseed; zero_state flags it.
//  Reset asserted in RUN/OUT aborts the burst immediately; all values return to reset values.
// TESTING
//  1. Rule 90, periodic, LOAD_SEED 64'h1, STEP 1 -> out_data=64'h8000_0000_0000_0002 one edge after accept.
//  2. Same seed, STEP 2 -> out_data=64'h4000_0000_0000_0004, out_valid rises exactly 2 edges after accept.
//  3. SET_RULE {bound=1,rule=90}, seed 64'h1, STEP 1 -> 64'h2; SET_RULE rule=30 null, seed 1, STEP 1 -> 64'h3.
//  4. SET_RULE rule=150 periodic, seed 1, STEP 1 -> 64'h8000_0000_0000_0003; STEP 0 afterwards returns same value unchanged.
//  5. Hold out_ready=0 for 10 cycles after STEP 3 -> out_valid, out_data stable, cmd_ready=0; release -> IDLE next edge.
//  6. reset low mid-RUN of STEP 200 -> out_valid=0, state=0, rule=90 at once; op 11 accepted -> cmd_err 1-cycle pulse, led_sig toggles.

Source files
------------

// File: rtl/ca_prng_if.sv
// ----------------------------------------------------------------------------
// ca_prng_if
//   Command/response bundle between the SPI command decoder, the cellular
//   automaton PRNG engine and the SPI response path.
//
//   cmd_valid  decoder -> engine   command present
//   cmd_ready  engine  -> decoder  engine can accept a command
//   cmd_op     decoder -> engine   00 STEP, 01 LOAD_SEED, 10 SET_RULE, 11 reserved
//   cmd_data   decoder -> engine   operand (step count / seed / rule+boundary)
//   out_valid  engine  -> consumer out_data holds a completed STEP result
//   out_ready  consumer-> engine   consumer takes out_data
//   out_data   engine  -> consumer CA state snapshot
//
//   modport master : the side that issues commands and consumes results
//   modport slave  : the engine
// ----------------------------------------------------------------------------
interface ca_prng_if #(
    parameter int WIDTH = 64
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output out_ready,
        input  cmd_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  out_ready,
        output cmd_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/ca_prng_engine.sv
// ----------------------------------------------------------------------------
// ca_prng_engine
//   One-dimensional elementary cellular-automaton pseudo-random generator.
//   Any 8-bit Wolfram rule, periodic or null boundary, multi-step bursts
//   driven by explicit command opcodes, valid/ready result port.
//
// Parameters
//   WIDTH          number of CA cells (>= 3)
//   STEP_W         width of the burst step count (max burst 2**STEP_W-1)
//   RULE_DEFAULT   Wolfram rule loaded at reset (0..255)
//   BOUND_DEFAULT  boundary at reset: 0 = periodic, 1 = null
//
// Ports
//   clk         clock
//   reset       asynchronous, active-low reset
//   bus         ca_prng_if.slave: cmd_valid/cmd_ready/cmd_op/cmd_data and
//               out_valid/out_ready/out_data
//   busy        high while a burst is running or a result awaits pickup
//   zero_state  CA state register is all zero
//   cmd_err     one-cycle pulse when a reserved opcode is accepted
//   led_sig     toggles on every accepted command
// ----------------------------------------------------------------------------
module ca_prng_engine #(
    parameter int WIDTH         = 64,
    parameter int STEP_W        = 8,
    parameter int RULE_DEFAULT  = 90,
    parameter int BOUND_DEFAULT = 0
) (
    input  logic       clk,
    input  logic       reset,
    ca_prng_if.slave   bus,
    output logic       busy,
    output logic       zero_state,
    output logic       cmd_err,
    output logic       led_sig
);

    localparam logic [1:0] OP_STEP     = 2'b00;
    localparam logic [1:0] OP_LOAD     = 2'b01;
    localparam logic [1:0] OP_SET_RULE = 2'b10;

    localparam logic [7:0] RULE_RST  = 8'(RULE_DEFAULT);
    localparam logic       BOUND_RST = (BOUND_DEFAULT != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_OUT
    } fsm_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    fsm_t              fsm_q,       fsm_d;
    logic [WIDTH-1:0]  ca_q,        ca_d;
    logic [7:0]        rule_q,      rule_d;
    logic              bound_q,     bound_d;
    logic [STEP_W-1:0] cnt_q,       cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic              cmd_err_q,   cmd_err_d;
    logic              led_q,       led_d;

    // ------------------------------------------------------------------
    // Operand fields. The command word may be narrower than the fields
    // it carries for small WIDTH, so missing bits read as zero.
    // ------------------------------------------------------------------
    logic [8:0]        cfg_field;   // [8] boundary, [7:0] rule
    logic [STEP_W-1:0] step_n;

    generate
        if (WIDTH >= 9) begin : g_cfg_slice
            assign cfg_field = bus.cmd_data[8:0];
        end else begin : g_cfg_ext
            assign cfg_field = 9'(bus.cmd_data);
        end

        if (STEP_W <= WIDTH) begin : g_step_slice
            assign step_n = bus.cmd_data[STEP_W-1:0];
        end else begin : g_step_ext
            assign step_n = STEP_W'(bus.cmd_data);
        end
    endgenerate

    // ------------------------------------------------------------------
    // One CA generation. The state is padded with one neighbour on each
    // side: ext[i+1] is cell i, ext[WIDTH+1] stands in for q[WIDTH] and
    // ext[0] for q[-1]. Null boundary forces both pads to zero.
    // ------------------------------------------------------------------
    logic               edge_hi;
    logic               edge_lo;
    logic [WIDTH+1:0]   ext;
    logic [WIDTH-1:0]   ca_next;

    assign edge_hi = bound_q ? 1'b0 : ca_q[0];
    assign edge_lo = bound_q ? 1'b0 : ca_q[WIDTH-1];
    assign ext     = {edge_hi, ca_q, edge_lo};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            // Neighbourhood {L, C, R} = {q[i+1], q[i], q[i-1]} indexes the rule.
            assign ca_next[gi] = rule_q[{ext[gi+2], ext[gi+1], ext[gi]}];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic accept;

    // Held low during reset so the decoder cannot push a command that
    // would be lost to the asynchronously cleared registers.
    assign bus.cmd_ready = reset & (fsm_q == ST_IDLE);
    assign accept        = bus.cmd_valid & bus.cmd_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d       = fsm_q;
        ca_d        = ca_q;
        rule_d      = rule_q;
        bound_d     = bound_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cmd_err_d   = 1'b0;
        led_d       = led_q;

        case (fsm_q)
            ST_IDLE: begin
                if (accept) begin
                    led_d = ~led_q;
                    case (bus.cmd_op)
                        OP_STEP: begin
                            if (step_n == '0) begin
                                // Zero-length burst: publish the current state as is.
                                out_data_d  = ca_q;
                                out_valid_d = 1'b1;
                                fsm_d       = ST_OUT;
                            end else begin
                                cnt_d = step_n;
                                fsm_d = ST_RUN;
                            end
                        end
                        OP_LOAD: begin
                            ca_d = bus.cmd_data;
                        end
                        OP_SET_RULE: begin
                            rule_d  = cfg_field[7:0];
                            bound_d = cfg_field[8];
                        end
                        default: begin
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end
            end

            ST_RUN: begin
                ca_d  = ca_next;
                cnt_d = cnt_q - 1'b1;
                // The edge applying the last step also publishes its result.
                if (cnt_q == STEP_W'(1)) begin
                    out_data_d  = ca_next;
                    out_valid_d = 1'b1;
                    fsm_d       = ST_OUT;
                end
            end

            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = ST_IDLE;
                end
            end

            default: begin
                fsm_d       = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q       <= ST_IDLE;
            ca_q        <= '0;
            rule_q      <= RULE_RST;
            bound_q     <= BOUND_RST;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cmd_err_q   <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            ca_q        <= ca_d;
            rule_q      <= rule_d;
            bound_q     <= bound_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cmd_err_q   <= cmd_err_d;
            led_q       <= led_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (fsm_q == ST_RUN) || (fsm_q == ST_OUT);
    assign zero_state    = ~|ca_q;
    assign cmd_err       = cmd_err_q;
    assign led_sig       = led_q;

endmodule

// File: tb/tb_ca_prng_engine.sv
// ----------------------------------------------------------------------------
// tb_ca_prng_engine
//   Directed, table-driven bench for ca_prng_engine (WIDTH=64, STEP_W=8,
//   rule 90 periodic at reset). Expected results are hand-computed.
// ----------------------------------------------------------------------------
module tb_ca_prng_engine;

    localparam int W = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, zero_state, cmd_err, led_sig;

    ca_prng_if #(.WIDTH(W)) bus ();

    ca_prng_engine #(
        .WIDTH(W), .STEP_W(8), .RULE_DEFAULT(90), .BOUND_DEFAULT(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .zero_state (zero_state),
        .cmd_err    (cmd_err),
        .led_sig    (led_sig)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_led = 1'b0;

    typedef struct {
        logic [8:0]   cfg;    // {boundary, rule}
        logic [W-1:0] seed;
        logic [7:0]   n;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] data);
        int w = 0;
        while (!bus.cmd_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_before_cmd", {63'b0, bus.cmd_ready}, 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(posedge clk);
        exp_led = ~exp_led;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("led_sig", {63'b0, led_sig}, {63'b0, exp_led});
        $display("cmd op=%0d data=%h led=%0b", op, data, led_sig);
    endtask

    // Counts rising edges (after the accept edge) until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("out_valid_after_take", {63'b0, bus.out_valid}, 64'd0);
        chk("cmd_ready_after_take", {63'b0, bus.cmd_ready}, 64'd1);
    endtask

    task automatic run_step(input string name, input logic [7:0] n, input logic [W-1:0] exp);
        int lat;
        send_cmd(2'b00, {56'b0, n});
        wait_out(lat);
        chk({name, "_latency"}, W'(lat), W'(n));
        chk({name, "_data"}, bus.out_data, exp);
        $display("step %s n=%0d lat=%0d out=%h", name, n, lat, bus.out_data);
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] held;

        //               cfg        seed                       n     expected
        vecs[0]  = '{{1'b0, 8'd90},  64'h1,                  8'd1, 64'h8000_0000_0000_0002};
        vecs[1]  = '{{1'b0, 8'd90},  64'h1,                  8'd2, 64'h4000_0000_0000_0004};
        vecs[2]  = '{{1'b1, 8'd90},  64'h1,                  8'd1, 64'h2};
        vecs[3]  = '{{1'b1, 8'd30},  64'h1,                  8'd1, 64'h3};
        vecs[4]  = '{{1'b0, 8'd150}, 64'h1,                  8'd1, 64'h8000_0000_0000_0003};
        vecs[5]  = '{{1'b0, 8'd90},  64'h1,                  8'd0, 64'h1};
        vecs[6]  = '{{1'b1, 8'd90},  64'h8000_0000_0000_0000, 8'd1, 64'h4000_0000_0000_0000};
        vecs[7]  = '{{1'b0, 8'd255}, 64'h0,                  8'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[8]  = '{{1'b0, 8'd90},  64'h0,                  8'd5, 64'h0};
        vecs[9]  = '{{1'b0, 8'd204}, 64'hDEAD_BEEF_0123_4567, 8'd3, 64'hDEAD_BEEF_0123_4567};
        vecs[10] = '{{1'b0, 8'd90},  64'h1,                  8'd3, 64'hA000_0000_0000_000A};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_zero_state", {63'b0, zero_state}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_led", {63'b0, led_sig}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", {63'b0, bus.cmd_ready}, 64'd1);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            send_cmd(2'b10, {55'b0, vecs[i].cfg});
            send_cmd(2'b01, vecs[i].seed);
            chk($sformatf("v%0d_zero_state", i), {63'b0, zero_state},
                {63'b0, (vecs[i].seed == 64'd0)});
            run_step($sformatf("v%0d", i), vecs[i].n, vecs[i].exp);
        end

        // Rule 150 then STEP 0 returns the same value unchanged
        send_cmd(2'b10, {55'b0, 1'b0, 8'd150});
        send_cmd(2'b01, 64'h1);
        run_step("r150_s1", 8'd1, 64'h8000_0000_0000_0003);
        run_step("r150_s0", 8'd0, 64'h8000_0000_0000_0003);

        // Back-pressure: hold out_ready low for 10 cycles after STEP 3
        send_cmd(2'b10, {55'b0, 1'b0, 8'd90});
        send_cmd(2'b01, 64'h1);
        send_cmd(2'b00, 64'd3);
        chk("run_busy", {63'b0, busy}, 64'd1);
        chk("run_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
        wait_out(lat);
        chk("hold_latency", W'(lat), 64'd3);
        chk("hold_data", bus.out_data, 64'hA000_0000_0000_000A);
        held = bus.out_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_out_valid", {63'b0, bus.out_valid}, 64'd1);
            chk("hold_out_data", bus.out_data, held);
            chk("hold_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
        end
        $display("hold released out=%h", bus.out_data);
        consume();
        chk("hold_busy_after", {63'b0, busy}, 64'd0);

        // Reset in the middle of a long burst (rule 30 null beforehand)
        send_cmd(2'b10, {55'b0, 1'b1, 8'd30});
        send_cmd(2'b01, 64'h1);
        send_cmd(2'b00, 64'd200);
        repeat (20) @(negedge clk);
        chk("midrun_busy", {63'b0, busy}, 64'd1);
        chk("midrun_zero_state", {63'b0, zero_state}, 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("abort_out_data", bus.out_data, 64'd0);
        chk("abort_zero_state", {63'b0, zero_state}, 64'd1);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_cmd_ready", {63'b0, bus.cmd_ready}, 64'd0);
        chk("abort_led", {63'b0, led_sig}, 64'd0);
        $display("reset asserted mid-run busy=%0b zero=%0b", busy, zero_state);
        exp_led = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Rule must be back to 90 periodic without any SET_RULE
        send_cmd(2'b01, 64'h1);
        run_step("post_rst_rule", 8'd1, 64'h8000_0000_0000_0002);

        // Reserved opcode
        send_cmd(2'b11, 64'h1234);
        chk("cmd_err_pulse", {63'b0, cmd_err}, 64'd1);
        chk("err_no_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        chk("cmd_err_clear", {63'b0, cmd_err}, 64'd0);
        chk("err_state_kept", {63'b0, zero_state}, 64'd0);
        run_step("after_err", 8'd0, 64'h8000_0000_0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
